// File: rtl/bouncing_sprites.sv
// bouncing_sprites: N_OBJ filled squares that bounce off the screen edges, moved once
// per enabled frame tick and drawn with lowest-index priority onto registered RGB.
module bouncing_sprites #(
   parameter int          H_RES     = 640,
   parameter int          V_RES     = 480,
   parameter int          HALF      = 20,
   parameter int          N_OBJ     = 4,
   parameter int          X_SPACING = 97,
   parameter int          Y_SPACING = 61,
   parameter logic [95:0] COLORS    = 96'h000_000_000_000_F00_0F0_00F_FFF
) (
   input  logic       clock25MHz,
   input  logic       reset,
   input  logic [9:0] x,
   input  logic [9:0] y,
   input  logic       frameTick,
   input  logic       enable,
   input  logic [1:0] speedSel,
   output logic [3:0] red,
   output logic [3:0] green,
   output logic [3:0] blue,
   output logic       hit
);

   localparam logic [10:0] HALF_L  = 11'(HALF);
   localparam logic [10:0] MAX_X   = 11'(H_RES - 1 - HALF);
   localparam logic [10:0] MAX_Y   = 11'(V_RES - 1 - HALF);
   localparam logic [10:0] H_RES_L = 11'(H_RES);
   localparam logic [10:0] V_RES_L = 11'(V_RES);

   generate
      if (N_OBJ < 1 || N_OBJ > 8) begin : g_badCount
         $error("bouncing_sprites: N_OBJ must be within 1..8");
      end
      for (genvar g = 0; g < N_OBJ; g++) begin : g_initCheck
         if ((HALF + 1 + g * X_SPACING) > (H_RES - 1 - HALF) ||
             (HALF + 1 + g * Y_SPACING) > (V_RES - 1 - HALF)) begin : g_badPos
            $error("bouncing_sprites: initial object position outside the screen");
         end
      end
   endgenerate

   // One axis step: returns {flipped, newDir, newPos}; reaching a wall exactly is a bounce.
   function automatic logic [11:0] stepAxis(input logic [9:0] pos, input logic dir,
                                            input logic [10:0] step, input logic [10:0] maxPos);
      logic [10:0] wide;
      logic [10:0] fwd;
      logic [10:0] back;
      logic [11:0] result;
      wide = {1'b0, pos};
      fwd  = wide + step;
      back = wide - step;
      if (dir) begin
         if (fwd >= maxPos) result = {1'b1, 1'b0, maxPos[9:0]};
         else               result = {1'b0, 1'b1, fwd[9:0]};
      end else begin
         if (wide <= HALF_L + step) result = {1'b1, 1'b1, HALF_L[9:0]};
         else                       result = {1'b0, 1'b0, back[9:0]};
      end
      return result;
   endfunction

   logic [9:0]       posX_r [N_OBJ];
   logic [9:0]       posY_r [N_OBJ];
   logic [N_OBJ-1:0] hDir_r;
   logic [N_OBJ-1:0] vDir_r;
   logic [11:0]      nextX_s [N_OBJ];
   logic [11:0]      nextY_s [N_OBJ];
   logic [10:0]      step_s;
   logic             anyFlip_s;
   logic             cover_s;
   logic [11:0]      pixel_s;

   assign step_s = {9'd0, speedSel} + 11'd1;

   // Candidate next positions/directions for every object and the combined bounce flag.
   always_comb begin
      anyFlip_s = 1'b0;
      for (int i = 0; i < N_OBJ; i++) begin
         nextX_s[i] = stepAxis(posX_r[i], hDir_r[i], step_s, MAX_X);
         nextY_s[i] = stepAxis(posY_r[i], vDir_r[i], step_s, MAX_Y);
         anyFlip_s  = anyFlip_s | nextX_s[i][11] | nextY_s[i][11];
      end
   end

   // Object state: staggered start positions, committed only on an enabled frame tick.
   always_ff @(posedge clock25MHz or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N_OBJ; i++) begin
            posX_r[i] <= 10'(HALF + 1 + i * X_SPACING);
            posY_r[i] <= 10'(HALF + 1 + i * Y_SPACING);
            hDir_r[i] <= 1'b1;
            vDir_r[i] <= ((i % 2) == 0) ? 1'b1 : 1'b0;
         end
      end else if (frameTick && enable) begin
         for (int i = 0; i < N_OBJ; i++) begin
            posX_r[i] <= nextX_s[i][9:0];
            hDir_r[i] <= nextX_s[i][10];
            posY_r[i] <= nextY_s[i][9:0];
            vDir_r[i] <= nextY_s[i][10];
         end
      end
   end

   // Pixel colour: walk from the highest index down so the lowest covering object wins.
   always_comb begin
      pixel_s = 12'h000;
      cover_s = 1'b0;
      for (int i = N_OBJ - 1; i >= 0; i--) begin
         cover_s = ({1'b0, posX_r[i]} <= {1'b0, x} + HALF_L) &&
                   ({1'b0, x} <= {1'b0, posX_r[i]} + HALF_L) &&
                   ({1'b0, posY_r[i]} <= {1'b0, y} + HALF_L) &&
                   ({1'b0, y} <= {1'b0, posY_r[i]} + HALF_L);
         pixel_s = cover_s ? COLORS[12*i +: 12] : pixel_s;
      end
      pixel_s = (({1'b0, x} < H_RES_L) && ({1'b0, y} < V_RES_L)) ? pixel_s : 12'h000;
   end

   // Registered RGB and the one-cycle bounce pulse.
   always_ff @(posedge clock25MHz or posedge reset) begin
      if (reset) begin
         red   <= 4'd0;
         green <= 4'd0;
         blue  <= 4'd0;
         hit   <= 1'b0;
      end else begin
         {red, green, blue} <= pixel_s;
         hit                <= frameTick & enable & anyFlip_s;
      end
   end

endmodule

// File: tb/tb_bouncing_sprites.sv
// Directed bench for bouncing_sprites: a pixel table on the default build plus
// hand-computed multi-tick sequences on small parameterisations for bounce corners.
module tb_bouncing_sprites;

   logic       clock25MHz;
   logic       reset;
   logic [9:0] x;
   logic [9:0] y;
   logic [3:0] tick;
   logic       enable;
   logic [1:0] speedSel;
   logic [3:0] red   [4];
   logic [3:0] green [4];
   logic [3:0] blue  [4];
   logic       hit   [4];

   int nChecks = 0;
   int nFails  = 0;

   typedef struct {
      logic [9:0]  px;
      logic [9:0]  py;
      logic [11:0] rgb;
   } pixVec_t;

   pixVec_t vecs [13];

   bouncing_sprites dut0 (
      .clock25MHz(clock25MHz), .reset(reset), .x(x), .y(y), .frameTick(tick[0]),
      .enable(enable), .speedSel(speedSel),
      .red(red[0]), .green(green[0]), .blue(blue[0]), .hit(hit[0]));

   bouncing_sprites #(.N_OBJ(1)) dut1 (
      .clock25MHz(clock25MHz), .reset(reset), .x(x), .y(y), .frameTick(tick[1]),
      .enable(enable), .speedSel(speedSel),
      .red(red[1]), .green(green[1]), .blue(blue[1]), .hit(hit[1]));

   bouncing_sprites #(.N_OBJ(1), .H_RES(64), .V_RES(64)) dut2 (
      .clock25MHz(clock25MHz), .reset(reset), .x(x), .y(y), .frameTick(tick[2]),
      .enable(enable), .speedSel(speedSel),
      .red(red[2]), .green(green[2]), .blue(blue[2]), .hit(hit[2]));

   bouncing_sprites #(.N_OBJ(2), .X_SPACING(0), .Y_SPACING(0)) dut3 (
      .clock25MHz(clock25MHz), .reset(reset), .x(x), .y(y), .frameTick(tick[3]),
      .enable(enable), .speedSel(speedSel),
      .red(red[3]), .green(green[3]), .blue(blue[3]), .hit(hit[3]));

   initial clock25MHz = 1'b0;
   always #20 clock25MHz = ~clock25MHz;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nFails++;
         $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // One-cycle tick to instance idx; returns on the negedge after the update edge.
   task automatic pulse(input int idx, input logic [1:0] sel);
      tick[idx] = 1'b1;
      speedSel  = sel;
      @(negedge clock25MHz);
      tick[idx] = 1'b0;
   endtask

   initial begin
      vecs[0]  = '{10'd21,  10'd21,  12'hFFF};
      vecs[1]  = '{10'd1,   10'd1,   12'hFFF};
      vecs[2]  = '{10'd41,  10'd41,  12'hFFF};
      vecs[3]  = '{10'd0,   10'd21,  12'h000};
      vecs[4]  = '{10'd42,  10'd21,  12'h000};
      vecs[5]  = '{10'd118, 10'd82,  12'h00F};
      vecs[6]  = '{10'd98,  10'd62,  12'h00F};
      vecs[7]  = '{10'd138, 10'd102, 12'h00F};
      vecs[8]  = '{10'd139, 10'd82,  12'h000};
      vecs[9]  = '{10'd215, 10'd143, 12'h0F0};
      vecs[10] = '{10'd312, 10'd204, 12'hF00};
      vecs[11] = '{10'd700, 10'd10,  12'h000};
      vecs[12] = '{10'd21,  10'd500, 12'h000};

      reset = 1'b1; tick = 4'd0; enable = 1'b0; speedSel = 2'd0; x = 10'd21; y = 10'd21;
      repeat (2) @(negedge clock25MHz);
      check("rst_rgb", {red[0], green[0], blue[0]}, 32'h000);
      check("rst_hit", hit[0], 32'd0);
      check("rst_x0", dut0.posX_r[0], 32'd21);
      check("rst_y1", dut0.posY_r[1], 32'd82);
      check("rst_x3", dut0.posX_r[3], 32'd312);
      check("rst_vdir1", dut0.vDir_r[1], 32'd0);
      check("rst_vdir2", dut0.vDir_r[2], 32'd1);
      reset = 1'b0;

      for (int i = 0; i < 13; i++) begin
         x = vecs[i].px;
         y = vecs[i].py;
         @(negedge clock25MHz);
         check($sformatf("pix%0d", i), {red[0], green[0], blue[0]}, {20'd0, vecs[i].rgb});
      end
      check("idle_hit", hit[0], 32'd0);

      // first step of 1 pixel
      enable = 1'b1;
      pulse(0, 2'd0);
      check("step_hit", hit[0], 32'd0);
      check("step_x0", dut0.posX_r[0], 32'd22);
      check("step_y0", dut0.posY_r[0], 32'd22);
      check("step_x1", dut0.posX_r[1], 32'd119);
      check("step_y1", dut0.posY_r[1], 32'd81);
      x = 10'd42; y = 10'd22;
      @(negedge clock25MHz);
      check("step_pixIn", {red[0], green[0], blue[0]}, 32'hFFF);
      x = 10'd1;
      @(negedge clock25MHz);
      check("step_pixOut", {red[0], green[0], blue[0]}, 32'h000);

      // frozen: ticks without enable
      enable = 1'b0;
      for (int i = 0; i < 10; i++) begin
         pulse(0, 2'd3);
         check("frz_hit", hit[0], 32'd0);
      end
      check("frz_x0", dut0.posX_r[0], 32'd22);
      check("frz_y0", dut0.posY_r[0], 32'd22);
      enable = 1'b1;

      // right-wall bounce on the single-object build: 148 steps of 4, then steps of 3
      repeat (148) pulse(1, 2'd3);
      pulse(1, 2'd2);
      check("wall_preX", dut1.posX_r[0], 32'd616);
      check("wall_preDir", dut1.hDir_r[0], 32'd1);
      check("wall_preY", dut1.posY_r[0], 32'd304);
      pulse(1, 2'd2);
      check("wall_x", dut1.posX_r[0], 32'd619);
      check("wall_dir", dut1.hDir_r[0], 32'd0);
      check("wall_hit", hit[1], 32'd1);
      @(negedge clock25MHz);
      check("wall_hitDrop", hit[1], 32'd0);
      pulse(1, 2'd2);
      check("wall_back", dut1.posX_r[0], 32'd616);

      // corner bounces on the 64x64 build (walls at 20 and 43)
      repeat (21) pulse(2, 2'd0);
      check("cor_preHit", hit[2], 32'd0);
      pulse(2, 2'd0);
      check("cor_maxX", dut2.posX_r[0], 32'd43);
      check("cor_maxY", dut2.posY_r[0], 32'd43);
      check("cor_maxDirs", {dut2.hDir_r[0], dut2.vDir_r[0]}, 32'd0);
      check("cor_maxHit", hit[2], 32'd1);
      repeat (22) pulse(2, 2'd0);
      check("cor_21", {dut2.posX_r[0], dut2.posY_r[0]}, {12'd0, 10'd21, 10'd21});
      check("cor_21Dirs", {dut2.hDir_r[0], dut2.vDir_r[0]}, 32'd0);
      pulse(2, 2'd0);
      check("cor_20", {dut2.posX_r[0], dut2.posY_r[0]}, {12'd0, 10'd20, 10'd20});
      check("cor_20Dirs", {dut2.hDir_r[0], dut2.vDir_r[0]}, 32'd3);
      check("cor_hit", hit[2], 32'd1);
      pulse(2, 2'd0);
      check("cor_hitOnce", hit[2], 32'd0);
      check("cor_back", {dut2.posX_r[0], dut2.posY_r[0]}, {12'd0, 10'd21, 10'd21});

      // overlapping objects: object 0 wins
      x = 10'd21; y = 10'd21;
      @(negedge clock25MHz);
      check("ovl_centre", {red[3], green[3], blue[3]}, 32'hFFF);
      x = 10'd41; y = 10'd1;
      @(negedge clock25MHz);
      check("ovl_edge", {red[3], green[3], blue[3]}, 32'hFFF);

      // reset landing on a tick cycle mid-animation
      pulse(0, 2'd1);
      pulse(0, 2'd1);
      x = 10'd26; y = 10'd26;
      @(negedge clock25MHz);
      check("mid_pix", {red[0], green[0], blue[0]}, 32'hFFF);
      tick[0] = 1'b1;
      reset   = 1'b1;
      #1;
      check("mid_rgb", {red[0], green[0], blue[0]}, 32'h000);
      check("mid_x0", dut0.posX_r[0], 32'd21);
      check("mid_y1", dut0.posY_r[1], 32'd82);
      check("mid_dirs", {dut0.hDir_r, dut0.vDir_r}, 32'hF5);
      check("mid_hit", hit[0], 32'd0);
      @(negedge clock25MHz);
      check("mid_hitHeld", hit[0], 32'd0);
      check("mid_xHeld", dut0.posX_r[0], 32'd21);
      tick[0] = 1'b0;
      reset   = 1'b0;
      @(negedge clock25MHz);
      check("rel_hit", hit[0], 32'd0);
      check("rel_x0", dut0.posX_r[0], 32'd21);
      pulse(0, 2'd0);
      check("rel_step", dut0.posX_r[0], 32'd22);
      check("rel_stepHit", hit[0], 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
